// File: rtl/ocm_arbiter.sv
// Two-master arbiter in front of a 4-word single-port on-chip memory.
// Grants are combinational with zero-latency acceptance; read data returns one cycle later.
module ocm_arbiter #(
  parameter int unsigned BURST_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  m0_address,
  input  logic [3:0]  m0_byteenable,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,
  input  logic [1:0]  m1_address,
  input  logic [3:0]  m1_byteenable,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,
  output logic [1:0]  mem_address,
  output logic [3:0]  mem_byteenable,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic        mem_clken,
  input  logic [31:0] mem_readdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t     state;
  logic [3:0] count;
  logic       last_grant;
  logic [1:0] rd_tag;
  logic       req0, req1;
  logic       grant0, grant1;
  logic       limit_hit;

  assign req0      = m0_read | m0_write;
  assign req1      = m1_read | m1_write;
  assign limit_hit = (count >= 4'(BURST_LIMIT));

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path infers a latch.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (req0 && req1) begin
            grant0 = last_grant;
            grant1 = ~last_grant;
          end else begin
            grant0 = req0;
            grant1 = req1;
          end
        end
        OWN0: begin
          if (req0 && (!req1 || !limit_hit)) grant0 = 1'b1;
          else                               grant1 = req1;
        end
        OWN1: begin
          if (req1 && (!req0 || !limit_hit)) grant1 = 1'b1;
          else                               grant0 = req0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    if (reset) begin
      state      <= IDLE;
      count      <= 4'd0;
      last_grant <= 1'b1;
      rd_tag     <= 2'b00;
    end else begin
      rd_tag <= {grant1 & m1_read & ~m1_write, grant0 & m0_read & ~m0_write};
      if (grant0) begin
        state      <= OWN0;
        last_grant <= 1'b0;
        if (state != OWN0)       count <= 4'd1;
        else if (count != 4'hF)  count <= count + 4'd1;
      end else if (grant1) begin
        state      <= OWN1;
        last_grant <= 1'b1;
        if (state != OWN1)       count <= 4'd1;
        else if (count != 4'hF)  count <= count + 4'd1;
      end else begin
        state <= IDLE;
        count <= 4'd0;
      end
    end
  end

  assign mem_chipselect = grant0 | grant1;
  assign mem_write      = (grant0 & m0_write) | (grant1 & m1_write);
  assign mem_address    = grant0 ? m0_address    : (grant1 ? m1_address    : 2'd0);
  assign mem_byteenable = grant0 ? m0_byteenable : (grant1 ? m1_byteenable : 4'd0);
  assign mem_writedata  = grant0 ? m0_writedata  : (grant1 ? m1_writedata  : 32'd0);
  assign mem_clken      = 1'b1;

  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;

  // The tag is gated by reset so a read issued just before reset never returns during it.
  assign m0_readdatavalid = rd_tag[0] & ~reset;
  assign m1_readdatavalid = rd_tag[1] & ~reset;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_ocm_arbiter.sv
// Scoreboard bench for ocm_arbiter: a driver predicts each cycle from a grant-history model,
// a monitor compares DUT outputs on the falling edge.
module tb_ocm_arbiter;

  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m1_read, m0_write, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [1:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;

  always #5 clk = ~clk;

  ocm_arbiter #(.BURST_LIMIT(BL)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  // Single-port memory with registered read output.
  logic [31:0] ram [4];
  logic [31:0] ram_q;
  assign mem_readdata = ram_q;
  initial begin
    for (int i = 0; i < 4; i++) ram[i] <= 32'd0;
    ram_q <= 32'd0;
  end
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      for (int b = 0; b < 4; b++)
        if (mem_write && mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      if (!mem_write) ram_q <= ram[mem_address];
    end
  end

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
  } req_t;

  typedef struct {
    bit         rst;
    bit         w0, w1, cs, we, v0, v1;
    logic [1:0] addr;
  } cyc_t;

  cyc_t        cyc_q[$];
  logic [31:0] rd_q0[$], rd_q1[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          max_wait = 0;

  logic [31:0] ref_mem [4];
  int          hist[$];
  bit          pend_v[2];
  logic [31:0] pend_d[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
  endtask

  function automatic req_t mk(input bit rd, input bit wr, input int addr, input int be,
                              input logic [31:0] data);
    req_t r;
    r.rd = rd; r.wr = wr; r.addr = 2'(addr); r.be = 4'(be); r.data = data;
    return r;
  endfunction

  function automatic req_t rand_req();
    int k = $urandom_range(0, 9);
    if (k < 3) return '0;
    return mk(k >= 6 || k == 3, k < 6, $urandom_range(0, 3), $urandom_range(0, 15), $urandom);
  endfunction

  // Grant prediction from the history of grants since reset (-1 = no grant that cycle).
  function automatic int predict(input bit r0, input bit r1);
    int prev = -1;
    int streak = 0;
    int last = 1;
    if (hist.size() > 0) prev = hist[hist.size()-1];
    for (int i = hist.size() - 1; i >= 0 && prev >= 0 && hist[i] == prev; i--) streak++;
    foreach (hist[i]) if (hist[i] >= 0) last = hist[i];
    if (r0 && r1) begin
      if (prev < 0) return 1 - last;
      return (streak >= BL) ? 1 - prev : prev;
    end
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic step(input req_t q0, input req_t q1, input bit rst, output int g);
    cyc_t  c;
    req_t  q;
    logic [31:0] mask;
    @(posedge clk);
    #1;
    reset = rst;
    m0_read = q0.rd; m0_write = q0.wr; m0_address = q0.addr; m0_byteenable = q0.be; m0_writedata = q0.data;
    m1_read = q1.rd; m1_write = q1.wr; m1_address = q1.addr; m1_byteenable = q1.be; m1_writedata = q1.data;
    c.rst = rst;
    c.v0 = pend_v[0] && !rst;
    c.v1 = pend_v[1] && !rst;
    if (c.v0) rd_q0.push_back(pend_d[0]);
    if (c.v1) rd_q1.push_back(pend_d[1]);
    pend_v[0] = 1'b0;
    pend_v[1] = 1'b0;
    if (rst) begin
      hist.delete();
      g = -1;
    end else begin
      g = predict(q0.rd | q0.wr, q1.rd | q1.wr);
      hist.push_back(g);
    end
    c.w0 = (q0.rd | q0.wr) && g != 0;
    c.w1 = (q1.rd | q1.wr) && g != 1;
    c.cs = g >= 0;
    c.we = 1'b0;
    c.addr = 2'd0;
    if (g >= 0) begin
      q = (g == 0) ? q0 : q1;
      c.we = q.wr;
      c.addr = q.addr;
      if (q.wr) begin
        mask = {{8{q.be[3]}}, {8{q.be[2]}}, {8{q.be[1]}}, {8{q.be[0]}}};
        ref_mem[q.addr] = (ref_mem[q.addr] & ~mask) | (q.data & mask);
      end else begin
        pend_v[g] = 1'b1;
        pend_d[g] = ref_mem[q.addr];
      end
    end
    cyc_q.push_back(c);
  endtask

  // Monitor: pops one expected cycle record per falling edge.
  initial begin
    cyc_t c;
    int   run0 = 0;
    int   run1 = 0;
    forever begin
      @(negedge clk);
      if (cyc_q.size() != 0) begin
        c = cyc_q.pop_front();
        check("waitrequest{m1,m0}", {m1_waitrequest, m0_waitrequest}, {c.w1, c.w0});
        check("mem{chipselect,write}", {mem_chipselect, mem_write}, {c.cs, c.we});
        if (c.cs) check("mem_address", mem_address, c.addr);
        check("readdatavalid{m1,m0}", {m1_readdatavalid, m0_readdatavalid}, {c.v1, c.v0});
        if (c.v0) check("m0_readdata", m0_readdata, rd_q0.pop_front());
        if (c.v1) check("m1_readdata", m1_readdata, rd_q1.pop_front());
        run0 = (c.rst || !m0_waitrequest) ? 0 : run0 + 1;
        run1 = (c.rst || !m1_waitrequest) ? 0 : run1 + 1;
        if (run0 > max_wait) max_wait = run0;
        if (run1 > max_wait) max_wait = run1;
      end
    end
  end

  initial begin
    req_t idle = '0;
    req_t c0 = '0;
    req_t c1 = '0;
    int   g;
    reset = 1'b1;
    m0_read = 0; m0_write = 0; m0_address = 0; m0_byteenable = 0; m0_writedata = 0;
    m1_read = 0; m1_write = 0; m1_address = 0; m1_byteenable = 0; m1_writedata = 0;
    for (int i = 0; i < 4; i++) ref_mem[i] = 32'd0;
    pend_v[0] = 1'b0;
    pend_v[1] = 1'b0;
    repeat (3) step(idle, idle, 1'b1, g);

    // Single master write then read back.
    step(mk(0, 1, 2, 'hF, 32'hDEADBEEF), idle, 0, g);
    step(mk(1, 0, 2, 0, 0), idle, 0, g);
    step(idle, idle, 0, g);

    // Byte lanes through m1.
    step(idle, mk(0, 1, 1, 'hF, 32'h11223344), 0, g);
    step(idle, mk(0, 1, 1, 'h8, 32'hAA000000), 0, g);
    step(idle, mk(1, 0, 1, 0, 0), 0, g);
    step(idle, idle, 0, g);

    // Read and write together: write wins, no read return.
    step(mk(1, 1, 3, 'hF, 32'h5A5AA5A5), idle, 0, g);
    step(mk(1, 0, 3, 0, 0), idle, 0, g);
    step(idle, idle, 0, g);

    // Tie right after reset, then m0 drops early.
    step(idle, idle, 1, g);
    step(mk(1, 0, 0, 0, 0), mk(1, 0, 1, 0, 0), 0, g);
    step(mk(1, 0, 0, 0, 0), mk(1, 0, 1, 0, 0), 0, g);
    step(idle, mk(1, 0, 1, 0, 0), 0, g);
    step(idle, idle, 0, g);

    // Both masters stream continuously.
    for (int i = 0; i < 14; i++)
      step(mk(1, 0, i % 4, 0, 0), mk(i % 2, (i + 1) % 2, (i + 1) % 4, 'hF, 32'(i) * 32'h01010101), 0, g);

    // m1 read granted, reset next cycle with requests held, then arbitrated after reset.
    step(idle, mk(1, 0, 2, 0, 0), 0, g);
    step(mk(1, 0, 1, 0, 0), mk(1, 0, 3, 0, 0), 1, g);
    step(mk(1, 0, 1, 0, 0), mk(1, 0, 3, 0, 0), 0, g);
    step(idle, idle, 0, g);

    // Random traffic; requests held until accepted.
    for (int i = 0; i < 500; i++) begin
      step(c0, c1, $urandom_range(0, 79) == 0, g);
      if (!(c0.rd | c0.wr) || g == 0) c0 = rand_req();
      if (!(c1.rd | c1.wr) || g == 1) c1 = rand_req();
    end

    repeat (3) step(idle, idle, 0, g);
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(cyc_q.size() + rd_q0.size() + rd_q1.size()), 32'd0);
    check("max_wait_within_limit", 32'(max_wait <= BL), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ocm_arbiter.md
OCM_ARBITER -- requirements
Module: ocm_arbiter

Interface
REQ-001 Parameter BURST_LIMIT, default 4: max consecutive grants to one master while the other waits; range 1..15.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  reset is synchronous and active-high.
REQ-004 m0_address / m1_address  in  2 each  word address into the 4-word memory.
REQ-005 m0_byteenable / m1_byteenable  in  4 each  byte lanes for writes.
REQ-006 m0_read / m1_read  in  1 each  read request, held until accepted.
REQ-007 m0_write / m1_write  in  1 each  write request, held until accepted.
REQ-008 m0_writedata / m1_writedata  in  32 each  write data.
REQ-009 m0_waitrequest / m1_waitrequest  out  1 each  high = request stalled this cycle.
REQ-010 m0_readdata / m1_readdata  out  32 each  read data, valid when readdatavalid is high.
REQ-011 m0_readdatavalid / m1_readdatavalid  out  1 each  one-cycle read-return strobe.
REQ-012 mem_address  out  2  memory word address.
REQ-013 mem_byteenable  out  4  memory byte enables.
REQ-014 mem_chipselect  out  1  memory select.
REQ-015 mem_write  out  1  memory write strobe.
REQ-016 mem_writedata  out  32  memory write data.
REQ-017 mem_clken  out  1  memory clock enable; constant 1.
REQ-018 mem_readdata  in  32  memory output; valid one cycle after the read address is presented.

Function
REQ-019 req_i = mi_read | mi_write; if both are high, the cycle is a write and the read is ignored.
REQ-020 FSM states: IDLE, OWN0, OWN1; a 4-bit burst counter; a last-grant flag.
REQ-021 IDLE: one requester -> grant it; both -> grant the master not equal to last-grant; none -> stay in IDLE.
REQ-022 OWNx: x requesting and (other idle or count < BURST_LIMIT) -> grant x, count+1, saturating at 15.
REQ-023 OWNx: other requesting and (x idle or count >= BURST_LIMIT) -> grant other, move to OWNother, count=1.
REQ-024 OWNx: no requester -> IDLE, count=0, no grant.
REQ-025 A grant entering any OWN state sets count=1 and updates last-grant.
REQ-026 Grant is combinational within the request cycle: granted master's address, byteenable, writedata and write drive mem_*; mem_chipselect=1; zero-latency acceptance.
REQ-027 mi_waitrequest = req_i & ~grant_i; it is low when the master is not requesting.
REQ-028 No grant: mem_chipselect=0, mem_write=0; other mem_* are don't-care and are driven to 0.
REQ-029 mem_write = grant & granted master's write.
REQ-030 Read grant in cycle N -> mi_readdatavalid=1 in cycle N+1 only, from a registered tag; mi_readdata = mem_readdata in that cycle.
REQ-031 readdata for the non-owning master is also mem_readdata; it is meaningful only under its own readdatavalid.
REQ-032 Back-to-back accesses: one grant may issue every cycle, including the cycle a previous read returns; throughput is 1 access/clk.
REQ-033 Read after write to the same address in the next cycle returns the new data, per single-port M9K write-then-read ordering.
REQ-034 At most one grant and at most one readdatavalid per cycle.

Reset
REQ-035 While reset is high: state=IDLE, count=0, last-grant=1 (so m0 wins the first tie), both readdatavalid=0, no grant issued, mem_chipselect=0.
REQ-036 A read granted in the cycle before reset produces no readdatavalid in the reset cycle.
REQ-037 Requests held through reset are arbitrated normally in the first cycle after reset deasserts.

Verification
REQ-038 Single master: m0 writes 0xDEADBEEF to addr 2 (be=0xF), then reads addr 2 -> m0_waitrequest is never high; m0_readdatavalid is high 1 clk after the read; m0_readdata=0xDEADBEEF.
REQ-039 Tie after reset: both masters read in the same cycle -> m0 is granted, m1_waitrequest=1; the next cycle m1 is granted only when BURST_LIMIT is reached or m0 drops its request.
REQ-040 Fairness: both masters stream continuously with BURST_LIMIT=4 -> grant pattern 0,0,0,0,1,1,1,1,0,... and no master waits more than 4 cycles.
REQ-041 Byte lanes: write 0x11223344 (be=0xF), then 0xAA000000 (be=0x8), then read -> 0xAA223344.
REQ-042 Reset mid-read: m1 read granted in cycle N, reset in cycle N+1 -> m1_readdatavalid=0 in N+1; state is IDLE after reset.
REQ-043 Simultaneous read+write from m0: write performed, no readdatavalid returned.
